// File: rtl/tp1_serial_tx.sv
// rtl/tp1_serial_tx.sv - TP1 readout transmitter: word FIFO feeding a 3-wire MSB-first serial link
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   in_valid  producer presents a word on in_data
//   in_data   word to transmit (DATA_W bits)
//   in_ready  FIFO not full; a word is taken when in_valid && in_ready
//   sclk_o    serial clock, low half then high half of each bit period
//   sdata_o   serial data, MSB first, stable across each bit period
//   frame_o   high for exactly the bit periods of one word
//   busy      FSM active or FIFO holding words
//   tx_done   one-cycle pulse in the last cycle of a word
//   level     FIFO occupancy
module tp1_serial_tx #(
  parameter int DATA_W  = 10,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     sclk_o,
  output logic                     sdata_o,
  output logic                     frame_o,
  output logic                     busy,
  output logic                     tx_done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_W);
  localparam int DW = $clog2(2 * CLK_DIV);

  localparam logic [LW-1:0] FULL     = LW'(DEPTH);
  localparam logic [DW-1:0] HALF_END = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] PER_PRE  = DW'(2 * CLK_DIV - 2);
  localparam logic [DW-1:0] PER_END  = DW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  // Holds the bits still to be sent; the current bit already sits in sdata_o.
  logic [DATA_W-2:0]   shreg;
  logic [BW-1:0]       bit_cnt;
  // Cycle counter within a bit period, reused to time the gap.
  logic [DW-1:0]       div;
  logic                push;
  logic                pop;

  assign in_ready = (level != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (state == LOAD);
  assign busy     = (state != IDLE) || (level != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div     <= '0;
      sclk_o  <= 1'b0;
      sdata_o <= 1'b0;
      frame_o <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          sclk_o  <= 1'b0;
          sdata_o <= 1'b0;
          frame_o <= 1'b0;
          if (level != '0) state <= LOAD;
        end
        LOAD: begin
          // Outputs are set here so frame_o and the MSB appear in the first SHIFT cycle.
          shreg   <= mem[rd_ptr][DATA_W-2:0];
          sdata_o <= mem[rd_ptr][DATA_W-1];
          frame_o <= 1'b1;
          sclk_o  <= 1'b0;
          bit_cnt <= LAST_BIT;
          div     <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          div <= div + DW'(1);
          if (div == HALF_END) sclk_o <= 1'b1;
          // Registered, so raising it one cycle early lands it on the final SHIFT cycle.
          if (div == PER_PRE && bit_cnt == '0) tx_done <= 1'b1;
          if (div == PER_END) begin
            div    <= '0;
            sclk_o <= 1'b0;
            if (bit_cnt == '0) begin
              frame_o <= 1'b0;
              sdata_o <= 1'b0;
              state   <= GAP;
            end else begin
              sdata_o <= shreg[DATA_W-2];
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt - BW'(1);
            end
          end
        end
        GAP: begin
          if (div == PER_END) begin
            div   <= '0;
            state <= (level != '0) ? LOAD : IDLE;
          end else begin
            div <= div + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tp1_serial_tx.sv
// tb/tb_tp1_serial_tx.sv - directed bench for tp1_serial_tx (CLK_DIV=2 and CLK_DIV=1 instances)
module tb_tp1_serial_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [9:0] in_data = '0;
  logic       in_ready, sclk_o, sdata_o, frame_o, busy, tx_done;
  logic [2:0] level;

  logic       in_valid1 = 1'b0;
  logic [9:0] in_data1 = '0;
  logic       in_ready1, sclk1, sdata1, frame1, busy1, tx_done1;
  logic [2:0] level1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tp1_serial_tx #(.DATA_W(10), .DEPTH(4), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sclk_o(sclk_o), .sdata_o(sdata_o), .frame_o(frame_o), .busy(busy),
    .tx_done(tx_done), .level(level)
  );

  tp1_serial_tx #(.DATA_W(10), .DEPTH(4), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .sclk_o(sclk1), .sdata_o(sdata1), .frame_o(frame1), .busy(busy1),
    .tx_done(tx_done1), .level(level1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Receiver model for the CLK_DIV=2 link: samples sdata_o on sclk_o rising edges.
  logic [9:0] rx_q[$];
  int         len_q[$];
  int         gap_q[$];
  logic [9:0] m_bits = '0;
  int         m_nb = 0, m_len = 0, m_low = 0, m_done = 0, m_spur = 0;
  logic       m_prev_f = 1'b0, m_prev_s = 1'b0, m_had = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      m_bits = '0; m_nb = 0; m_len = 0; m_low = 0;
      m_prev_f = 1'b0; m_prev_s = 1'b0; m_had = 1'b0;
    end else begin
      if (tx_done) m_done++;
      if (!frame_o && (sclk_o || sdata_o)) m_spur++;
      if (frame_o) begin
        if (!m_prev_f) begin
          if (m_had) gap_q.push_back(m_low);
          m_len = 0; m_nb = 0; m_bits = '0;
        end
        m_len++;
        if (sclk_o && !m_prev_s) begin
          m_bits = {m_bits[8:0], sdata_o};
          m_nb++;
        end
      end else begin
        if (m_prev_f) begin
          rx_q.push_back(m_bits);
          len_q.push_back(m_len);
          m_had = 1'b1;
          m_low = 0;
        end
        m_low++;
      end
      m_prev_f = frame_o;
      m_prev_s = sclk_o;
    end
  end

  task automatic push_word(input logic [9:0] w);
    int n = 0;
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("push_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || frame_o) && n < budget);
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_done && n < 200);
    check("done_timeout", tx_done, 1);
  endtask

  logic [9:0] t2_words [6] = '{10'h3FF, 10'h000, 10'h155, 10'h2AA, 10'h001, 10'h200};
  logic [9:0] t4_words [7] = '{10'h101, 10'h202, 10'h0F0, 10'h30C, 10'h0AB, 10'h354, 10'h1E7};

  initial begin
    int n, rb, gb, db, idx, bad, full_seen, full_lvl_ok, len, prev_s;
    logic [9:0] bits;

    repeat (3) @(negedge clk);
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sclk", sclk_o, 0);
    check("rst_sdata", sdata_o, 0);
    check("rst_frame", frame_o, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_done", tx_done, 0);
    #2 rst = 1'b0;

    // Quiet link with no stimulus
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sclk_o || frame_o || sdata_o || busy || tx_done) bad++;
    end
    check("quiet_outputs", bad, 0);

    // Single word 0x2A5
    db = m_done;
    rb = rx_q.size();
    push_word(10'h2A5);
    @(negedge clk);
    check("t1_frame_n1", frame_o, 0);
    @(negedge clk);
    check("t1_frame_load", frame_o, 0);
    @(negedge clk);
    check("t1_frame_rise", frame_o, 1);
    check("t1_msb", sdata_o, 1);
    n = 0;
    while (frame_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("t1_frame_len", n, 40);
    check("t1_busy_gap", busy, 1);
    repeat (3) @(negedge clk);
    check("t1_busy_gap_end", busy, 1);
    @(negedge clk);
    check("t1_busy_fall", busy, 0);
    check("t1_rx_count", rx_q.size() - rb, 1);
    if (rx_q.size() > rb) check("t1_rx_word", rx_q[rb], 10'h2A5);
    check("t1_done_pulses", m_done - db, 1);

    // Six words with in_valid held
    rb = rx_q.size();
    gb = gap_q.size();
    idx = 0;
    full_seen = 0;
    full_lvl_ok = 1;
    for (int c = 0; c < 2000 && idx < 6; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = t2_words[idx];
      if (!in_ready) begin
        full_seen = 1;
        if (level != 3'd4) full_lvl_ok = 0;
      end
      n = in_ready;
      @(posedge clk);
      if (n != 0) idx++;
    end
    #1 in_valid = 1'b0;
    check("t2_all_pushed", idx, 6);
    check("t2_full_seen", full_seen, 1);
    check("t2_full_level", full_lvl_ok, 1);
    wait_idle(600);
    check("t2_rx_count", rx_q.size() - rb, 6);
    for (int i = 0; i < 6; i++)
      if (rb + i < rx_q.size()) begin
        check($sformatf("t2_word%0d", i), rx_q[rb + i], t2_words[i]);
        check($sformatf("t2_len%0d", i), len_q[rb + i], 40);
      end
    for (int i = 1; i < 6; i++)
      if (gb + i < gap_q.size()) check($sformatf("t2_gap%0d", i), gap_q[gb + i], 5);
    check("t2_level_end", level, 0);

    // Full FIFO across LOAD, then push and pop on the same edge
    rb = rx_q.size();
    for (int i = 0; i < 5; i++) push_word(t4_words[i]);
    @(negedge clk);
    check("t4_full_level", level, 4);
    check("t4_full_ready", in_ready, 0);
    in_data  = t4_words[5];
    in_valid = 1'b1;
    wait_done();
    repeat (4) @(negedge clk);
    check("t4_gap_level", level, 4);
    @(negedge clk);
    check("t4_load_level", level, 4);
    check("t4_load_ready", in_ready, 0);
    @(negedge clk);
    check("t4_after_pop_level", level, 3);
    check("t4_after_pop_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("t4_refill_level", level, 4);
    wait_done();
    repeat (5) @(negedge clk);
    check("t4_load2_level", level, 4);
    wait_done();
    repeat (5) @(negedge clk);
    check("t4_load3_level", level, 3);
    in_data  = t4_words[6];
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("t4_push_pop_level", level, 3);
    wait_idle(800);
    check("t4_rx_count", rx_q.size() - rb, 7);
    for (int i = 0; i < 7; i++)
      if (rb + i < rx_q.size()) check($sformatf("t4_word%0d", i), rx_q[rb + i], t4_words[i]);

    // Reset mid-word
    push_word(10'h3FF);
    push_word(10'h3FF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_nb != 4 && n < 200);
    check("t3_reach_bit3", m_nb, 4);
    #2 rst = 1'b1;
    #1;
    check("t3_rst_sclk", sclk_o, 0);
    check("t3_rst_sdata", sdata_o, 0);
    check("t3_rst_frame", frame_o, 0);
    check("t3_rst_level", level, 0);
    check("t3_rst_busy", busy, 0);
    check("t3_rst_ready", in_ready, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("t3_post_busy", busy, 0);
    rb = rx_q.size();
    push_word(10'h155);
    wait_idle(200);
    check("t3_rx_count", rx_q.size() - rb, 1);
    if (rx_q.size() > rb) begin
      check("t3_rx_word", rx_q[rb], 10'h155);
      check("t3_rx_len", len_q[rb], 40);
    end
    check("idle_spurious", m_spur, 0);

    // CLK_DIV=1 instance
    @(negedge clk);
    in_data1  = 10'h3FF;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    n = 0;
    while (!frame1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_latency", n, 3);
    len = 0;
    bad = 0;
    bits = '0;
    prev_s = 0;
    while (frame1 && len < 100) begin
      len++;
      if (sdata1 !== 1'b1) bad++;
      if (len > 1 && int'(sclk1) == prev_s) bad++;
      if (sclk1 && prev_s == 0) bits = {bits[8:0], sdata1};
      prev_s = int'(sclk1);
      @(negedge clk);
    end
    check("t6_frame_len", len, 20);
    check("t6_toggle_data", bad, 0);
    check("t6_word", bits, 10'h3FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
